c_mac_frame: RTL and testbench
==============================

C_MAC_FRAME -- requirements
Module: c_mac_frame

Interface
REQ-001 The module SHALL have parameter N, default 16, meaning input component width (signed two's complement).
REQ-002 The module SHALL have parameter Q, default 8, meaning fractional bits per input and the right-shift applied to the result.
REQ-003 The module SHALL have parameter MAX_LEN, default 256, meaning maximum products per accumulation frame.
REQ-004 The module SHALL have parameter ACC_W, default 2N+1+clog2(MAX_LEN), meaning accumulator width; smaller values SHALL be a static elaboration error.
REQ-005 The module SHALL have parameter OUT_W, default 32, meaning output component width.
REQ-006 The module SHALL have parameter MULT_LAT, default 4 (minimum 1), meaning internal complex-multiplier pipeline depth in cycles.
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 The module SHALL have port mac_clear, input, 1 bit: synchronous flush.
REQ-010 The module SHALL have port conj_b, input, 1 bit: when 1, multiply by the conjugate of b.
REQ-011 The module SHALL have port acc_len, input, clog2(MAX_LEN)+1 bits: products per frame.
REQ-012 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-013 The module SHALL have ports in_ar, in_ai, in_br, in_bi, input, N bits each: operand components.
REQ-014 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-015 The module SHALL have ports out_r and out_i, output, OUT_W bits: rounded and saturated frame sums.
REQ-016 The module SHALL have port out_ovf, output, 1 bit: saturation occurred in out_r or out_i of the current result.

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 The pipeline advance enable adv SHALL equal NOT (out_valid AND NOT out_ready).
REQ-019 in_ready SHALL equal adv AND NOT mac_clear AND rst, combinationally.
REQ-020 When adv=0, every multiplier stage, the accumulator, and the counter SHALL hold their values; no product SHALL be lost or duplicated.
REQ-021 With conj_b=0, products SHALL be full precision (2N+1 bits, no truncation): pr=ar*br-ai*bi and pi=ai*br+ar*bi.
REQ-022 With conj_b=1, products SHALL be pr=ar*br+ai*bi and pi=ai*br-ar*bi.
REQ-023 conj_b SHALL be sampled with each accepted beat and travel with that beat through the pipeline.
REQ-024 Each product SHALL reach the accumulator MULT_LAT advancing cycles after its beat is accepted, then be sign-extended to ACC_W and added.
REQ-025 The frame length L SHALL be latched from acc_len when the first product of a frame reaches the accumulator.
REQ-026 acc_len=0 SHALL give L=1, and acc_len>MAX_LEN SHALL give L=MAX_LEN.
REQ-027 When the L-th product arrives, acc+product SHALL be rounded and loaded into the output registers with out_valid=1.
REQ-028 In that same cycle, the accumulator and counter SHALL reset to 0, so back-to-back frames run with no bubble.
REQ-029 Rounding SHALL compute (sum + 2^(Q-1)) >>> Q as an arithmetic shift (round half up); for Q=0 no rounding SHALL be applied.
REQ-030 Each component SHALL then be saturated to the signed OUT_W range, and out_ovf SHALL be set if either component clipped.
REQ-031 out_valid, out_r, out_i and out_ovf SHALL stay stable until a cycle where out_valid=1 and out_ready=1.
REQ-032 On that handshake cycle, out_valid SHALL clear unless a new result loads in the same cycle, in which case it stays 1 with the new data.
REQ-033 With no stalls, out_valid SHALL rise MULT_LAT+1 edges after the edge accepting the L-th beat.
REQ-034 mac_clear=1 SHALL, on the next edge, zero all pipeline valids, the accumulator and the counter.
REQ-035 mac_clear SHALL leave a pending result (out_valid=1) intact.
REQ-036 mac_clear SHALL take priority over a simultaneous beat (in_ready=0) and over a simultaneous L-th product, which SHALL be discarded.

Reset
REQ-037 While rst=0, out_valid, out_r, out_i, out_ovf, the accumulator, the counter, all pipeline valids and the latched L SHALL be 0, and in_ready SHALL be 0.
REQ-038 Reset asserted mid-frame SHALL discard all in-flight data, and in_ready SHALL be 1 on the first edge after release if out_ready is irrelevant.

Verification
REQ-039 The bench SHALL check: acc_len=4, four beats a=(256,0), b=(512,256), out_ready=1 -> out_r=2048, out_i=1024, out_ovf=0, out_valid exactly MULT_LAT+1 edges after the fourth beat.
REQ-040 The bench SHALL check: acc_len=1, a=(0,256), b=(0,256) with conj_b=0 -> out_r=-256, out_i=0; with conj_b=1 -> out_r=256, out_i=0.
REQ-041 The bench SHALL check rounding: acc_len=1, a=(1,0), b=(128,0) -> out_r=1; b=(-128,0) -> out_r=0; b=(-129,0) -> out_r=-1.
REQ-042 The bench SHALL check: out_ready=0, acc_len=1, five beats offered -> first result held, in_ready drops; after out_ready=1, five results arrive in order, none lost or duplicated.
REQ-043 The bench SHALL check: OUT_W=16, acc_len=256, a=b=(32767,0) -> out_r=32767, out_ovf=1.
REQ-044 The bench SHALL check: mac_clear after 2 of 4 beats, then 4 fresh beats -> result contains only the fresh beats; rst=0 mid-frame -> all outputs 0 and no stale result afterward.

Source files
------------

// File: rtl/c_mac_frame.sv
// -----------------------------------------------------------------------------
// c_mac_frame
//   Complex multiply-accumulate over frames of programmable length.
//   Each accepted beat carries a = (in_ar, in_ai) and b = (in_br, in_bi). The
//   beat's full-precision product a*b, or a*conj(b) when conj_b is set, goes
//   through a MULT_LAT-deep pipeline and is added into a wide accumulator.
//   After L products the sum is rounded (round half up, >>> Q), saturated to
//   OUT_W bits and presented on a valid/ready output port. The accumulator
//   restarts in that same cycle, so consecutive frames run with no bubble.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   mac_clear  : synchronous flush of the pipeline, accumulator and counter.
//                A pending output result is kept.
//   conj_b     : 1 = multiply by conj(b); sampled with each beat
//   acc_len    : products per frame (0 -> 1, > MAX_LEN -> MAX_LEN)
//   in_valid / in_ready                : input handshake
//   in_ar, in_ai, in_br, in_bi         : signed operand components
//   out_valid / out_ready              : result handshake
//   out_r, out_i                       : rounded, saturated frame sums
//   out_ovf                            : either component of this result clipped
// -----------------------------------------------------------------------------
module c_mac_frame #(
  parameter int N        = 16,
  parameter int Q        = 8,
  parameter int MAX_LEN  = 256,
  parameter int ACC_W    = 2*N + 1 + $clog2(MAX_LEN),
  parameter int OUT_W    = 32,
  parameter int MULT_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_clear,
  input  logic                       conj_b,
  input  logic [$clog2(MAX_LEN):0]   acc_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [N-1:0]        in_ar,
  input  logic signed [N-1:0]        in_ai,
  input  logic signed [N-1:0]        in_br,
  input  logic signed [N-1:0]        in_bi,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_r,
  output logic signed [OUT_W-1:0]    out_i,
  output logic                       out_ovf
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int P_W   = 2*N + 1;
  // Rounding needs one bit above ACC_W; saturation needs at least OUT_W bits.
  localparam int EXT_W = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
  localparam logic signed [EXT_W-1:0] RND =
    (Q > 0) ? (EXT_W'(1) <<< ((Q > 0) ? Q - 1 : 0)) : '0;

  generate
    if (ACC_W < 2*N + 1 + $clog2(MAX_LEN)) begin : g_acc_w_chk
      $error("c_mac_frame: ACC_W too small for N and MAX_LEN");
    end
    if (MULT_LAT < 1) begin : g_lat_chk
      $error("c_mac_frame: MULT_LAT must be at least 1");
    end
  endgenerate

  // Round half up with an arithmetic shift, then clip to signed OUT_W.
  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] s);
    logic signed [EXT_W-1:0] t;
    logic                    fits;
    t    = EXT_W'(s);
    t    = t + RND;
    t    = t >>> Q;
    // The value fits when every bit from OUT_W-1 upward equals the sign.
    fits = (&t[EXT_W-1:OUT_W-1]) | ~(|t[EXT_W-1:OUT_W-1]);
    if (fits) begin
      return {1'b0, t[OUT_W-1:0]};
    end
    return {1'b1, t[EXT_W-1], {(OUT_W-1){~t[EXT_W-1]}}};
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) begin
      return LEN_W'(1);
    end
    if (l > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return l;
  endfunction

  logic w_adv;
  logic w_accept;

  // The whole pipeline moves only when the output register can take a result.
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv & ~mac_clear & rst;
  assign w_accept = in_valid & in_ready;

  // ---- stage p0: operand capture ---------------------------------------------
  logic                r_vld_p0;
  logic                r_conj_p0;
  logic signed [N-1:0] r_ar_p0, r_ai_p0, r_br_p0, r_bi_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
    end else if (mac_clear) begin
      r_vld_p0 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p0 <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ar_p0   <= in_ar;
      r_ai_p0   <= in_ai;
      r_br_p0   <= in_br;
      r_bi_p0   <= in_bi;
      r_conj_p0 <= conj_b;
    end
  end

  // ---- stage p1..pMULT_LAT: complex product and delay line --------------------
  logic signed [P_W-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [P_W-1:0] w_rr, w_ii, w_ir, w_ri;
  logic signed [P_W-1:0] w_pr, w_pi;

  // Operands are widened first so the products carry the full 2N+1 bits.
  assign w_ar_x = P_W'(r_ar_p0);
  assign w_ai_x = P_W'(r_ai_p0);
  assign w_br_x = P_W'(r_br_p0);
  assign w_bi_x = P_W'(r_bi_p0);
  assign w_rr   = w_ar_x * w_br_x;
  assign w_ii   = w_ai_x * w_bi_x;
  assign w_ir   = w_ai_x * w_br_x;
  assign w_ri   = w_ar_x * w_bi_x;
  assign w_pr   = r_conj_p0 ? (w_rr + w_ii) : (w_rr - w_ii);
  assign w_pi   = r_conj_p0 ? (w_ir - w_ri) : (w_ir + w_ri);

  logic                  r_vld_p [1:MULT_LAT];
  logic signed [P_W-1:0] r_pr_p  [1:MULT_LAT];
  logic signed [P_W-1:0] r_pi_p  [1:MULT_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= MULT_LAT; i++) begin
        r_vld_p[i] <= 1'b0;
      end
    end else if (mac_clear) begin
      for (int i = 1; i <= MULT_LAT; i++) begin
        r_vld_p[i] <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld_p[1] <= r_vld_p0;
      for (int i = 2; i <= MULT_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_pr_p[1] <= w_pr;
      r_pi_p[1] <= w_pi;
      for (int i = 2; i <= MULT_LAT; i++) begin
        r_pr_p[i] <= r_pr_p[i-1];
        r_pi_p[i] <= r_pi_p[i-1];
      end
    end
  end

  // ---- accumulate stage -------------------------------------------------------
  logic signed [ACC_W-1:0] r_acc_r, r_acc_i;
  logic        [LEN_W-1:0] r_cnt;
  logic        [LEN_W-1:0] r_len;
  logic signed [ACC_W-1:0] w_prod_r, w_prod_i;
  logic signed [ACC_W-1:0] w_sum_r, w_sum_i;
  logic        [LEN_W-1:0] w_len_in, w_len_eff, w_cnt_inc;
  logic                    w_last_vld;
  logic                    w_end;
  logic                    w_fire;
  logic        [OUT_W:0]   w_rnd_r, w_rnd_i;

  assign w_last_vld = r_vld_p[MULT_LAT];
  assign w_prod_r   = ACC_W'(r_pr_p[MULT_LAT]);
  assign w_prod_i   = ACC_W'(r_pi_p[MULT_LAT]);
  assign w_sum_r    = r_acc_r + w_prod_r;
  assign w_sum_i    = r_acc_i + w_prod_i;
  assign w_len_in   = clamp_len(acc_len);
  // The first product of a frame uses acc_len directly, since it is latched
  // into r_len on that same edge.
  assign w_len_eff  = (r_cnt == '0) ? w_len_in : r_len;
  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_end      = w_last_vld & (w_cnt_inc == w_len_eff);
  assign w_fire     = w_adv & w_end & ~mac_clear;
  assign w_rnd_r    = round_sat(w_sum_r);
  assign w_rnd_i    = round_sat(w_sum_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_r <= '0;
      r_acc_i <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else if (mac_clear) begin
      r_acc_r <= '0;
      r_acc_i <= '0;
      r_cnt   <= '0;
    end else if (w_adv && w_last_vld) begin
      if (r_cnt == '0) begin
        r_len <= w_len_in;
      end
      if (w_end) begin
        r_acc_r <= '0;
        r_acc_i <= '0;
        r_cnt   <= '0;
      end else begin
        r_acc_r <= w_sum_r;
        r_acc_i <= w_sum_i;
        r_cnt   <= w_cnt_inc;
      end
    end
  end

  // ---- output register --------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_ovf   <= 1'b0;
    end else if (w_fire) begin
      // A new result may replace one being handed off in this same cycle.
      out_valid <= 1'b1;
      out_r     <= w_rnd_r[OUT_W-1:0];
      out_i     <= w_rnd_i[OUT_W-1:0];
      out_ovf   <= w_rnd_r[OUT_W] | w_rnd_i[OUT_W];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c_mac_frame.sv
module tb_c_mac_frame;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               mac_clear;
  logic               conj_b;
  logic [8:0]         acc_len;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_ar, in_ai, in_br, in_bi;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_r, out_i;
  logic               out_ovf;

  int checks   = 0;
  int failures = 0;

  c_mac_frame #(
    .N(16), .Q(8), .MAX_LEN(256), .OUT_W(16), .MULT_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mac_clear(mac_clear), .conj_b(conj_b),
    .acc_len(acc_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_ovf(out_ovf)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until an edge accepts it.
  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input logic cj);
    int n;
    n        = 0;
    in_ar    = 16'(ar);
    in_ai    = 16'(ai);
    in_br    = 16'(br);
    in_bi    = 16'(bi);
    conj_b   = cj;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    tick();
  endtask

  task automatic get_result(input string tag, input int er, input int ei,
                            input int eo);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_r"},   out_r,     er);
    check({tag, "_i"},   out_i,     ei);
    check({tag, "_ovf"}, out_ovf,   eo);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic seen;
    rst       = 1'b0;
    mac_clear = 1'b0;
    conj_b    = 1'b0;
    acc_len   = 9'd4;
    in_valid  = 1'b0;
    in_ar     = '0;
    in_ai     = '0;
    in_br     = '0;
    in_bi     = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r",     out_r,     0);
    check("rst_out_i",     out_i,     0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_in_ready",  in_ready,  0);
    rst = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // Four-beat frame and latency
    acc_len = 9'd4;
    for (int i = 0; i < 4; i++) send(256, 0, 512, 256, 1'b0);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("A_latency", k, LAT + 1);
    get_result("A", 2048, 1024, 0);

    // Conjugate selection travels with each beat
    acc_len = 9'd1;
    send(0, 256, 0, 256, 1'b0);
    send(0, 256, 0, 256, 1'b1);
    in_valid = 1'b0;
    get_result("B_noconj", -256, 0, 0);
    get_result("B_conj",    256, 0, 0);

    // Rounding, half up
    send(1, 0,  128, 0, 1'b0);
    send(1, 0, -128, 0, 1'b0);
    send(1, 0, -129, 0, 1'b0);
    in_valid = 1'b0;
    get_result("C_p128",  1, 0, 0);
    get_result("C_m128",  0, 0, 0);
    get_result("C_m129", -1, 0, 0);

    // acc_len = 0 behaves as a one-product frame
    acc_len = 9'd0;
    send(256, 0, 256, 0, 1'b0);
    in_valid = 1'b0;
    get_result("L0", 256, 0, 0);

    // Output backpressure: hold, stall, then drain in order
    acc_len   = 9'd1;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(i * 256, 0, 256, 0, 1'b0);
    in_valid = 1'b0;
    repeat (10) tick();
    check("D_hold_vld",   out_valid, 1);
    check("D_hold_r",     out_r,     256);
    check("D_in_ready",   in_ready,  0);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) get_result($sformatf("D%0d", i), i * 256, 0, 0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= out_valid;
    end
    check("D_nodup", seen, 0);

    // Saturation over a full 256-product frame
    acc_len = 9'd256;
    for (int i = 0; i < 256; i++) send(32767, 0, 32767, 0, 1'b0);
    in_valid = 1'b0;
    get_result("E_sat", 32767, 0, 1);

    // mac_clear mid-frame discards the partial frame
    acc_len = 9'd4;
    send(256, 0, 25600, 0, 1'b0);
    send(256, 0, 25600, 0, 1'b0);
    in_valid  = 1'b0;
    mac_clear = 1'b1;
    #1;
    check("F_clr_in_ready", in_ready, 0);
    tick();
    mac_clear = 1'b0;
    for (int i = 0; i < 4; i++) send(256, 0, 256, 0, 1'b0);
    in_valid = 1'b0;
    get_result("F_fresh", 1024, 0, 0);

    // Reset mid-frame
    send(256, 0, 256, 0, 1'b0);
    send(256, 0, 256, 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("G_rst_vld",      out_valid, 0);
    check("G_rst_r",        out_r,     0);
    check("G_rst_i",        out_i,     0);
    check("G_rst_ovf",      out_ovf,   0);
    check("G_rst_in_ready", in_ready,  0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("G_rel_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen |= out_valid;
    end
    check("G_no_stale", seen, 0);
    for (int i = 0; i < 4; i++) send(256, 0, 512, 0, 1'b0);
    in_valid = 1'b0;
    get_result("G_fresh", 2048, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
